// File: rtl/fwd_pkg.sv
// Shared types, constants and helpers for the forwarding / load-use hazard unit.
package fwd_pkg;

    // Widest register address the tracked entries can hold; narrower ADDR_W is zero-extended.
    localparam int unsigned RD_W = 8;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            load;
        logic [RD_W-1:0] rd;
    } entry_t;

    localparam entry_t BUBBLE_ENTRY = '{valid: 1'b0, reg_write: 1'b0, load: 1'b0, rd: '0};

    function automatic int unsigned sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic is_producer(input entry_t e, input logic [RD_W-1:0] r);
        return e.valid && e.reg_write && (e.rd == r) && (e.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher: returns the lowest stage index 1..DEPTH whose entry produces src, else 0.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned   DEPTH = 2,
    localparam int unsigned  SEL_W = sel_width(DEPTH)
) (
    input  entry_t [DEPTH:1] entries,
    input  logic [RD_W-1:0]  src,
    output logic [SEL_W-1:0] sel
);

    logic [DEPTH-1:0] unused_load;

    // Walk oldest to youngest so the youngest producer overwrites older matches.
    always_comb begin
        sel = '0;
        unused_load = '0;
        for (int k = int'(DEPTH); k >= 1; k--) begin
            unused_load[k-1] = entries[k].load;
            if (is_producer(entries[k], src)) begin
                sel = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding and ID load-use hazard detection over a DEPTH-stage result pipeline.
// Optional `FWD_STATS_EN adds wrapping 32-bit stall and forward counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned  ADDR_W     = 5,
    parameter int unsigned  DEPTH      = 2,
    parameter int unsigned  LOAD_STAGE = 2,
    localparam int unsigned SEL_W      = sel_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic [ADDR_W-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic              stall_id,
`ifdef FWD_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt,
`endif
    output logic              bubble_ex
);

    if (ADDR_W > RD_W || DEPTH < 1 || DEPTH > 6 || LOAD_STAGE < 1 || LOAD_STAGE > DEPTH)
    begin : g_param_check
        $error("fwd_hazard_unit: unsupported parameter combination");
    end

    // entries_q[0] is the instruction in EX, entries_q[k] the one in result stage k.
    entry_t [DEPTH:0] entries_q, entries_d;
    logic [RD_W-1:0]  ex_rs_q, ex_rs_d;
    logic [RD_W-1:0]  ex_rt_q, ex_rt_d;
    logic [RD_W-1:0]  id_rs, id_rt, id_rd;
    logic             hazard;

    assign id_rs = RD_W'(id_rs_addr);
    assign id_rt = RD_W'(id_rt_addr);
    assign id_rd = RD_W'(id_rd_addr);

    // A load is not yet forwardable while it sits before LOAD_STAGE.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k + 1 < int'(LOAD_STAGE); k++) begin
            if (entries_q[k].load &&
                (is_producer(entries_q[k], id_rs) || is_producer(entries_q[k], id_rt))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && id_valid;
    end

    assign stall_id  = hazard && !flush;
    assign bubble_ex = stall_id || flush || !id_valid;

    always_comb begin
        entries_d = entries_q;
        ex_rs_d   = ex_rs_q;
        ex_rt_d   = ex_rt_q;
        if (advance) begin
            for (int k = 1; k <= int'(DEPTH); k++) begin
                entries_d[k] = entries_q[k-1];
            end
            if (bubble_ex) begin
                entries_d[0] = BUBBLE_ENTRY;
                ex_rs_d      = '0;
                ex_rt_d      = '0;
            end else begin
                entries_d[0] = '{valid: id_valid, reg_write: id_reg_write,
                                 load: id_mem_read, rd: id_rd};
                ex_rs_d      = id_rs;
                ex_rt_d      = id_rt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= {(DEPTH + 1){BUBBLE_ENTRY}};
            ex_rs_q   <= '0;
            ex_rt_q   <= '0;
        end else begin
            entries_q <= entries_d;
            ex_rs_q   <= ex_rs_d;
            ex_rt_q   <= ex_rt_d;
        end
    end

    fwd_match #(
        .DEPTH (DEPTH)
    ) u_match_a (
        .entries (entries_q[DEPTH:1]),
        .src     (ex_rs_q),
        .sel     (fwd_a)
    );

    fwd_match #(
        .DEPTH (DEPTH)
    ) u_match_b (
        .entries (entries_q[DEPTH:1]),
        .src     (ex_rt_q),
        .sel     (fwd_b)
    );

`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt_q, fwd_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (advance) begin
            if (stall_id) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (fwd_a != '0 || fwd_b != '0) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

`ifndef SYNTHESIS
    // Hazard detection must keep immature loads from ever being chosen as a source.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int k = 1; k < int'(LOAD_STAGE); k++) begin
                assert (!(entries_q[k].load && (fwd_a == SEL_W'(k) || fwd_b == SEL_W'(k))))
                    else $error("fwd_hazard_unit: immature load in stage %0d selected", k);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default build plus a DEPTH=3 / LOAD_STAGE=3 instance.
module tb_fwd_hazard_unit;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
    } id_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       adv0, flush0, adv1, flush1;
    id_t        in0, in1;
    logic [1:0] fa0, fb0, fa1, fb1;
    logic       st0, bb0, st1, bb1;
`ifdef FWD_STATS_EN
    logic [31:0] sc0, fc0, sc1, fc1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .advance      (adv0),
        .flush        (flush0),
        .id_valid     (in0.valid),
        .id_rs_addr   (in0.rs),
        .id_rt_addr   (in0.rt),
        .id_rd_addr   (in0.rd),
        .id_reg_write (in0.reg_write),
        .id_mem_read  (in0.mem_read),
        .fwd_a        (fa0),
        .fwd_b        (fb0),
        .stall_id     (st0),
`ifdef FWD_STATS_EN
        .stall_cnt    (sc0),
        .fwd_cnt      (fc0),
`endif
        .bubble_ex    (bb0)
    );

    fwd_hazard_unit #(
        .DEPTH      (3),
        .LOAD_STAGE (3)
    ) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .advance      (adv1),
        .flush        (flush1),
        .id_valid     (in1.valid),
        .id_rs_addr   (in1.rs),
        .id_rt_addr   (in1.rt),
        .id_rd_addr   (in1.rd),
        .id_reg_write (in1.reg_write),
        .id_mem_read  (in1.mem_read),
        .fwd_a        (fa1),
        .fwd_b        (fb1),
        .stall_id     (st1),
`ifdef FWD_STATS_EN
        .stall_cnt    (sc1),
        .fwd_cnt      (fc1),
`endif
        .bubble_ex    (bb1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int u, input logic v, input logic rw, input logic mr,
                         input logic [4:0] rd_n, input logic [4:0] rs_n, input logic [4:0] rt_n);
        id_t x;
        x = '{valid: v, reg_write: rw, mem_read: mr, rd: rd_n, rs: rs_n, rt: rt_n};
        if (u == 0) in0 = x;
        else in1 = x;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; adv0 = 1'b1; adv1 = 1'b1; flush0 = 1'b0; flush1 = 1'b0;
        in0 = '0; in1 = '0;
        #2;
        chk("rst_fa", fa0, 0);
        chk("rst_fb", fb0, 0);
        chk("rst_stall", st0, 0);
        chk("rst_bubble_idle", bb0, 1);
        chk("rst3_fa", fa1, 0);
        chk("rst3_bubble_idle", bb1, 1);
        drive(0, 1, 1, 0, 3, 1, 2);
        chk("rst_bubble_valid", bb0, 0);
        tick; tick;
        rst_n = 1'b1;

        // RAW chain: add r3<-r1,r2 ; sub r4<-r3,r5 ; xor r7<-r8,r9 ; and r11<-r3,r4
        drive(0, 1, 1, 0, 3, 1, 2);
        chk("raw_first_stall", st0, 0);
        chk("raw_first_bubble", bb0, 0);
        tick;
        drive(0, 1, 1, 0, 4, 3, 5); tick;
        drive(0, 1, 1, 0, 7, 8, 9);
        chk("raw_fa_stage1", fa0, 1);
        chk("raw_fb_none", fb0, 0);
        tick;
        drive(0, 1, 1, 0, 11, 3, 4);
        chk("indep_fa", fa0, 0);
        chk("indep_fb", fb0, 0);
        tick;
        // Double producer of r3, then reader r13<-r3,r3
        drive(0, 1, 1, 0, 3, 0, 0);
        chk("aged_out_fa", fa0, 0);
        chk("raw_fb_stage2", fb0, 2);
        tick;
        drive(0, 1, 1, 0, 3, 0, 0); tick;
        drive(0, 1, 1, 0, 13, 3, 3); tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("youngest_fa", fa0, 1);
        chk("youngest_fb", fb0, 1);
        chk("idle_bubble", bb0, 1);
        tick;
        // or r14<-r13,r3 with a bubble in between
        drive(0, 1, 1, 0, 14, 13, 3); tick;
        drive(0, 1, 1, 0, 0, 1, 1);
        chk("gap_fa", fa0, 2);
        chk("gap_fb_aged", fb0, 0);
        tick;
        // Non-writing store to r5, then reader r15<-r0,r5
        drive(0, 1, 0, 0, 5, 1, 2); tick;
        drive(0, 1, 1, 0, 15, 0, 5); tick;
        // Load-use: lw r2 ; add r6<-r2,r2
        drive(0, 1, 1, 1, 2, 1, 0);
        chk("r0_fa", fa0, 0);
        chk("nowrite_fb", fb0, 0);
        chk("lw_nostall", st0, 0);
        tick;
        drive(0, 1, 1, 0, 6, 2, 2);
        chk("lu_stall", st0, 1);
        chk("lu_bubble", bb0, 1);
        tick;
        chk("lu_stall_done", st0, 0);
        chk("lu_nobubble", bb0, 0);
        chk("lu_bubble_fa", fa0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("lu_fa", fa0, 2);
        chk("lu_fb", fb0, 2);
        tick;
        // Flush coincident with load-use hazard
        drive(0, 1, 1, 1, 8, 1, 0); tick;
        drive(0, 1, 1, 0, 9, 8, 0);
        chk("fl_pre_stall", st0, 1);
        flush0 = 1'b1;
        #1;
        chk("fl_stall", st0, 0);
        chk("fl_bubble", bb0, 1);
        tick;
        flush0 = 1'b0;
        drive(0, 1, 1, 0, 10, 9, 8);
        chk("fl_next_stall", st0, 0);
        tick;
        drive(0, 1, 1, 1, 4, 1, 0);
        chk("fl_fa", fa0, 0);
        chk("fl_fb", fb0, 2);
        tick;
        // Freeze mid-stall
        drive(0, 1, 1, 0, 5, 4, 4);
        chk("frz_stall0", st0, 1);
        adv0 = 1'b0;
        repeat (3) begin
            tick;
            chk("frz_stall", st0, 1);
            chk("frz_bubble", bb0, 1);
            chk("frz_fa", fa0, 0);
        end
        adv0 = 1'b1;
        #1;
        chk("frz_resume_stall", st0, 1);
        tick;
        chk("frz_stall_end", st0, 0);
        tick;
        chk("frz_after_fa", fa0, 2);
        chk("frz_after_fb", fb0, 2);
        // Reset mid-stall with a live forward: lw r6<-r5 ; add r7<-r6,r5
        drive(0, 1, 1, 1, 6, 5, 0); tick;
        drive(0, 1, 1, 0, 7, 6, 5);
        chk("rst_pre_stall", st0, 1);
        chk("rst_pre_fa", fa0, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", st0, 0);
        chk("mid_rst_fa", fa0, 0);
        chk("mid_rst_fb", fb0, 0);
        chk("mid_rst_bubble", bb0, 0);
`ifdef FWD_STATS_EN
        chk("mid_rst_stall_cnt", sc0, 0);
        chk("mid_rst_fwd_cnt", fc0, 0);
`endif
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_bubble_idle", bb0, 1);
        tick;
        rst_n = 1'b1;
        tick;
        chk("post_rst_fa", fa0, 0);

        // DEPTH=3, LOAD_STAGE=3: two stall cycles, then select 3
        drive(1, 1, 1, 1, 2, 1, 0);
        chk("b_lw_nostall", st1, 0);
        tick;
        drive(1, 1, 1, 0, 6, 2, 2);
        chk("b_stall1", st1, 1);
        chk("b_bubble1", bb1, 1);
        tick;
        chk("b_stall2", st1, 1);
        tick;
        chk("b_stall_end", st1, 0);
        chk("b_nobubble", bb1, 0);
        tick;
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("b_fa", fa1, 3);
        chk("b_fb", fb1, 3);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined CPU. It internally tracks the destination of every in-flight instruction from ID/EX through the last write-back stage, and produces the EX-stage operand forward selects. It detects load-use hazards in ID and issues a stall plus bubble. It sits beside the ID/EX register, replaces the fixed two-stage combinational forwarding logic, and is driven by the same pipeline advance and flush controls as the pipeline registers.

## Interface
- ADDR_W, 5, register address width
- DEPTH, 2, number of result-holding stages after EX (1 = EX/MEM, 2 = MEM/WB, ...); range 1..6
- LOAD_STAGE, 2, first stage index at which load data is forwardable; range 1..DEPTH
- SEL_W, $clog2(DEPTH+1), width of forward selects (derived, not overridable)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- advance  in  1  pipeline enable; 0 freezes all internal state
- flush  in  1  kill the instruction leaving ID (branch/jump redirect)
- id_valid  in  1  ID holds a real instruction
- id_rs_addr, id_rt_addr  in  ADDR_W  source registers of the ID instruction
- id_rd_addr  in  ADDR_W  final (already muxed) destination of the ID instruction
- id_reg_write, id_mem_read  in  1  decoded controls of the ID instruction
- fwd_a, fwd_b  out  SEL_W  EX operand select: 0 = register file, k = result held in stage k
- stall_id  out  1  hold PC and IF/ID this cycle
- bubble_ex  out  1  ID/EX must load a bubble at the next advancing edge

## Operation
- State: entry[0..DEPTH], each {valid, reg_write, load, rd}; entry[0] = instruction in EX, entry[k] = instruction in stage k. Also ex_rs and ex_rt, the sources of entry[0].
- An entry k is a producer for address r when valid && reg_write && rd == r && rd != 0.
- fwd_a: the lowest k in 1..DEPTH that is a producer for ex_rs, else 0. fwd_b is the same using ex_rt. The youngest producer wins, generalising the EX/MEM-over-MEM/WB priority.
- Hazard: for k in 0..LOAD_STAGE-2, entry[k] is a load producer for id_rs_addr or id_rt_addr, with id_valid=1.
- stall_id = hazard && !flush.
- bubble_ex = stall_id || flush || !id_valid.
- On an advancing edge (advance=1):
  - entry[k+1] <= entry[k].
  - entry[0] gets {id_valid, id_reg_write, id_mem_read, id_rd_addr} with ex_rs/ex_rt updated from ID, unless bubble_ex is set. A bubble loads valid=0 and addresses 0.
- advance=0: all state holds, and outputs stay stable (they are functions of state and ID inputs only).
- Simultaneous flush and hazard: flush wins, stall_id=0, and a bubble is inserted.
- Load producers at k < LOAD_STAGE are never selected for forwarding. The hazard logic guarantees this cannot occur, and verification asserts it.

## Timing
- Reset (async assert, any cycle including mid-stall): all entries invalid, ex_rs/ex_rt = 0, fwd_a = fwd_b = 0, stall_id = 0, bubble_ex = !id_valid. Deassertion is synchronised externally.
- fwd_a/fwd_b: zero-latency combinational decode of registered state, valid throughout the EX cycle.
- stall_id: combinational from ID inputs in the same cycle.
- For default parameters, a dependent instruction directly after a load stalls exactly 1 cycle. In general it stalls LOAD_STAGE-1 cycles.
- A stall is held across advance=0 cycles without being consumed.

## Configuration
- FWD_STATS_EN defined: adds outputs stall_cnt and fwd_cnt, both 32-bit and wrapping.
  - stall_cnt increments on each advancing edge with stall_id=1.
  - fwd_cnt increments on each advancing edge where fwd_a != 0 or fwd_b != 0, by 1 per edge, not per operand.
  - Both clear on reset.
- FWD_STATS_EN undefined: neither port nor counter exists.

## Structure
- fwd_pkg: entry struct typedef (valid, reg_write, load, rd), the SEL_W computation function, and the bubble-entry constant.
- Sub-module fwd_match: priority matcher over entry[1..DEPTH] for one source address, returning the select. It is instantiated twice (rs, rt).
- The shift register, hazard detect and optional counters live in the top level.

## Test plan
- RAW chain with defaults: add r3 <- r1,r2, then sub r4 <- r3,r5 -> fwd_a=1 in sub's EX; with one independent instruction between them -> fwd_a=2.
- Double producer: two back-to-back writes to r3, then a reader -> fwd_a=1 (youngest), never 2.
- Load-use: lw r2 followed by add r6 <- r2,r2 -> stall_id=1 for 1 cycle, bubble enters EX, then fwd_a=fwd_b=2. Repeat with LOAD_STAGE=3, DEPTH=3 -> 2 stall cycles, then select 3.
- r0 and bubbles: writes to r0, or reg_write=0 writes matching rs -> fwd_a=0. Flush coincident with a load-use hazard -> stall_id=0 and a bubble is inserted.
- Freeze and reset: advance=0 for 3 cycles mid-stall -> state and outputs constant, stall resumes afterward. rst_n pulsed low mid-sequence -> all outputs reach reset values immediately; with FWD_STATS_EN, counters read 0.
